mdr_unit: RTL

//  Parametrised memory data register with its own memory handshake. Holds one word

---
 rtl/mdr_pkg.sv | 5 +
 rtl/mdr_if.sv | 24 ++
 rtl/mdr_lane_ext.sv | 30 +++
 rtl/mdr_unit.sv | 85 ++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// mdr_pkg: shared state and transfer-size encodings for the memory data register.
package mdr_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_t;
endpackage

// File: rtl/mdr_if.sv
// mdr_if: bus-side and memory-side signals of mdr_unit; MDR_BYTE_LANE_EN adds size/sgn/addr_lo/mem_be.
interface mdr_if import mdr_pkg::*; #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] mdr_q;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic mdr_in, mem_rd, mem_wr, mem_ack;
  logic mem_req, mem_we, busy, done, err;
`ifdef MDR_BYTE_LANE_EN
  size_t size;
  logic sgn;
  logic [1:0] addr_lo;
  logic [WIDTH/8-1:0] mem_be;
  modport slave(input BusMuxOut, mdr_in, mem_rd, mem_wr, mem_rdata, mem_ack, size, sgn, addr_lo,
                output mdr_q, mem_req, mem_we, mem_wdata, busy, done, err, mem_be);
  modport master(output BusMuxOut, mdr_in, mem_rd, mem_wr, mem_rdata, mem_ack, size, sgn, addr_lo,
                 input mdr_q, mem_req, mem_we, mem_wdata, busy, done, err, mem_be);
`else
  modport slave(input BusMuxOut, mdr_in, mem_rd, mem_wr, mem_rdata, mem_ack,
                output mdr_q, mem_req, mem_we, mem_wdata, busy, done, err);
  modport master(output BusMuxOut, mdr_in, mem_rd, mem_wr, mem_rdata, mem_ack,
                 input mdr_q, mem_req, mem_we, mem_wdata, busy, done, err);
`endif
endinterface

// File: rtl/mdr_lane_ext.sv
// mdr_lane_ext: read-lane extract/extend and write-lane replicate/byte-enable (used with MDR_BYTE_LANE_EN).
module mdr_lane_ext import mdr_pkg::*; #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0]   rd_data,
  input  size_t              rd_size,
  input  logic               rd_sgn,
  input  logic [1:0]         rd_addr,
  output logic [WIDTH-1:0]   rd_ext,
  input  logic [WIDTH-1:0]   st_data,
  input  size_t              st_size,
  input  logic [1:0]         st_addr,
  output logic [WIDTH-1:0]   st_rep,
  output logic [WIDTH/8-1:0] st_be,
  output logic               misalign
);
  localparam int NB = WIDTH / 8;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rd_data[{rd_addr, 3'b000} +: 8];
    h = rd_data[{rd_addr[1], 4'b0000} +: 16];
    rd_ext = rd_size == SZ_BYTE ? {{(WIDTH-8){rd_sgn & b[7]}}, b} :
             rd_size == SZ_HALF ? {{(WIDTH-16){rd_sgn & h[15]}}, h} : rd_data;
    st_rep = st_size == SZ_BYTE ? {NB{st_data[7:0]}} :
             st_size == SZ_HALF ? {(NB/2){st_data[15:0]}} : st_data;
    st_be = st_size == SZ_BYTE ? NB'(1) << st_addr :
            st_size == SZ_HALF ? NB'(3) << st_addr : '1;
    // anything other than byte/half is treated as a full word and must be lane 0
    misalign = st_size == SZ_HALF ? st_addr[0] : st_size != SZ_BYTE && st_addr != 2'd0;
  end
endmodule

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register with req/ack memory handshake and wait-state timeout; MDR_BYTE_LANE_EN enables sub-word transfers.
module mdr_unit import mdr_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input logic clock,
  input logic reset,
  mdr_if.slave bus
);
  localparam int CW = CNT_W < 1 ? 1 : CNT_W;
  state_t state;
  logic [CW-1:0] cnt;
  logic start, timeout, misalign;
  logic [WIDTH-1:0] wsrc, wdata_n, rdata_n;
  assign start = bus.mem_rd | bus.mem_wr;
  assign wsrc = bus.mdr_in ? bus.BusMuxOut : bus.mdr_q;
  assign timeout = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
`ifdef MDR_BYTE_LANE_EN
  size_t size_r;
  logic sgn_r;
  logic [1:0] addr_r;
  logic [WIDTH/8-1:0] be_n;
  mdr_lane_ext #(.WIDTH(WIDTH)) u_lane (
    .rd_data(bus.mem_rdata), .rd_size(size_r), .rd_sgn(sgn_r), .rd_addr(addr_r), .rd_ext(rdata_n),
    .st_data(wsrc), .st_size(bus.size), .st_addr(bus.addr_lo), .st_rep(wdata_n), .st_be(be_n),
    .misalign(misalign)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      size_r <= SZ_BYTE;
      sgn_r <= 1'b0;
      addr_r <= 2'd0;
      bus.mem_be <= '0;
    end else if (state == IDLE && start && !misalign) begin
      size_r <= bus.size;
      sgn_r <= bus.sgn;
      addr_r <= bus.addr_lo;
      bus.mem_be <= be_n;
    end
`else
  assign wdata_n = wsrc;
  assign rdata_n = bus.mem_rdata;
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.mdr_q <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_wdata <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (start && misalign) begin
          bus.done <= 1'b1;
          bus.err <= 1'b1;
        end else if (start) begin
          state <= bus.mem_rd ? RD : WR;
          cnt <= '0;
          bus.mem_req <= 1'b1;
          bus.busy <= 1'b1;
          bus.err <= 1'b0;
          bus.mem_we <= !bus.mem_rd;
          // a read takes priority and ignores mdr_in; a write may load the bus word through
          if (!bus.mem_rd) bus.mem_wdata <= wdata_n;
          if (!bus.mem_rd && bus.mdr_in) bus.mdr_q <= bus.BusMuxOut;
        end else if (bus.mdr_in) bus.mdr_q <= bus.BusMuxOut;
      end else if (bus.mem_ack || timeout) begin
        state <= IDLE;
        cnt <= '0;
        bus.mem_req <= 1'b0;
        bus.mem_we <= 1'b0;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        if (bus.mem_ack && state == RD) bus.mdr_q <= rdata_n;
        if (!bus.mem_ack) bus.err <= 1'b1;
      end else cnt <= cnt + CW'(1);
    end
endmodule
